mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage MIPS pipeline.
- Sequences each bus transaction with a small FSM, gives data access priority over fetch with a starvation bound, and drives per-port stall outputs to the hazard logic.
- Supports cancelling an in-flight fetch on a branch/jump flush.

Parameters:
- ADDR_W, 32, address width of both ports and the bus
- DATA_W, 32, data width of both ports and the bus
- MAX_DSTREAK, 4, maximum consecutive data grants while a fetch is pending (1..15)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- ireq  in  1  fetch request; held with iaddr stable until iresp_valid or iflush
- iaddr  in  ADDR_W  fetch address (pc)
- iflush  in  1  one-cycle pulse that cancels the current or pending fetch
- iresp_valid  out  1  fetch complete this cycle
- irdata  out  DATA_W  instruction; valid only when iresp_valid=1
- istall  out  1  ireq & ~iresp_valid
- dreq  in  1  data request; held with dwe, daddr and dwdata stable until dresp_valid
- dwe  in  1  1=write, 0=read
- daddr  in  ADDR_W  data address
- dwdata  in  DATA_W  store data
- dresp_valid  out  1  data access complete this cycle
- drdata  out  DATA_W  load data; valid only when dresp_valid=1 and dwe=0
- dstall  out  1  dreq & ~dresp_valid
- bus_valid  out  1  transaction active on the bus
- bus_we  out  1  write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus store data
- bus_ready  in  1  memory accepts/completes the transaction this cycle; bus_rdata is valid in the same cycle
- bus_rdata  in  DATA_W  bus read data

Behaviour:
- States: IDLE, IBUSY, DBUSY. Reset asserted (reset=0): state=IDLE, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, dstreak=0, idiscard=0. All resp outputs and stalls are 0, except that stall terms follow the req inputs combinationally.
- IDLE arbitration, evaluated each cycle:
  - ireq_eff = ireq & ~iflush.
  - dreq & (~ireq_eff | dstreak<MAX_DSTREAK) -> DBUSY; latch bus_we=dwe, bus_addr=daddr, bus_wdata=dwdata.
  - else ireq_eff -> IBUSY; latch bus_we=0, bus_addr=iaddr.
  - else stay in IDLE.
- bus_valid=1 in IBUSY/DBUSY and 0 in IDLE. The bus outputs are registered and stay constant for the whole busy state.
- Busy state, bus_ready=0: hold the state; no timeout.
- Busy state, bus_ready=1, completion is combinational in the same cycle:
  - IBUSY: iresp_valid = ~idiscard & ~iflush; irdata=bus_rdata.
  - DBUSY: dresp_valid=1; drdata=bus_rdata.
  - Next state is IDLE; idiscard clears.
- Minimum of 2 cycles per access (grant cycle + ready cycle). The requester may change req/addr in the cycle after its resp.
- dstreak, 4-bit saturating counter:
  - On a D grant with ireq_eff=1: dstreak+1.
  - On a D grant with ireq_eff=0: dstreak=0.
  - On any I grant: dstreak=0.
- Example with MAX_DSTREAK=4: with both ports requesting continuously, the grant order is D,D,D,D,I,D,...
- iflush:
  - In IBUSY without bus_ready: set idiscard. The bus transaction is not aborted and completes silently; iresp_valid stays 0.
  - In IBUSY with bus_ready in the same cycle: response suppressed.
  - In IDLE: blocks an I grant that cycle only.
  - In DBUSY: no effect on the data access.
- Writes: dresp_valid on bus_ready; drdata is don't-care.
- Async reset in a busy state: return to IDLE immediately. The outstanding bus transaction is abandoned and no resp is produced.

Test Plan:
- Lone fetch: ireq=1, iaddr=0x00400000, bus_ready 1 cycle after bus_valid, bus_rdata=0x8C080004 -> bus_addr=0x00400000, bus_we=0, iresp_valid=1 exactly 2 cycles after ireq, irdata=0x8C080004, istall high until then.
- Simultaneous requests: ireq=1 and dreq=1 (dwe=1, daddr=0x10010000, dwdata=0xDEADBEEF), zero-wait bus -> data granted first with bus_we=1 and bus_wdata=0xDEADBEEF, then fetch; dresp at cycle 2, iresp at cycle 4.
- Starvation bound: MAX_DSTREAK=4, dreq and ireq held continuously -> grant sequence D,D,D,D,I,D; dstreak back to 0 after the I grant.
- Flush mid-fetch: IBUSY with bus_ready held low for 3 cycles, iflush pulsed in cycle 1 -> bus_valid stays until bus_ready, iresp_valid never asserts, next I grant uses the new iaddr=0x00400020.
- Wait states: dreq read, bus_ready after 5 cycles, bus_rdata=0x12345678 -> bus outputs stable for 5 cycles, dstall=1 for 5 cycles, dresp_valid single pulse with drdata=0x12345678.
- Reset mid-transaction: reset=0 during DBUSY -> bus_valid=0 immediately, no dresp_valid; after release with dreq still high, a fresh grant occurs 1 cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-port memory bus shared by instruction fetch and data access.
// Data has priority. A bounded streak of data grants keeps a pending fetch from starving.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              iflush,
  output logic              iresp_valid,
  output logic [DATA_W-1:0] irdata,
  output logic              istall,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              dresp_valid,
  output logic [DATA_W-1:0] drdata,
  output logic              dstall,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DSTREAK);

  state_t     state;
  logic [3:0] dstreak;
  logic       idiscard;
  logic       ireq_eff;
  logic       grant_d;
  logic       grant_i;

  // A flush in the same cycle as a fetch request withdraws that request from arbitration.
  assign ireq_eff = ireq & ~iflush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = dreq & (~ireq_eff | (dstreak < STREAK_LIMIT));
      grant_i = ~grant_d & ireq_eff;
    end
  end

  assign bus_valid   = (state != IDLE);
  assign iresp_valid = (state == IBUSY) & bus_ready & ~idiscard & ~iflush;
  assign dresp_valid = (state == DBUSY) & bus_ready;
  assign irdata      = bus_rdata;
  assign drdata      = bus_rdata;
  assign istall      = ireq & ~iresp_valid;
  assign dstall      = dreq & ~dresp_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      dstreak   <= 4'd0;
      idiscard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DBUSY;
            bus_we    <= dwe;
            bus_addr  <= daddr;
            bus_wdata <= dwdata;
            if (ireq_eff)
              dstreak <= (dstreak == 4'hF) ? dstreak : dstreak + 4'd1;
            else
              dstreak <= 4'd0;
          end else if (grant_i) begin
            state    <= IBUSY;
            bus_we   <= 1'b0;
            bus_addr <= iaddr;
            dstreak  <= 4'd0;
          end
        end
        IBUSY: begin
          if (bus_ready) begin
            state    <= IDLE;
            idiscard <= 1'b0;
          end else if (iflush) begin
            // The bus cycle cannot be aborted, so it runs to completion and its data is dropped.
            idiscard <= 1'b1;
          end
        end
        DBUSY: begin
          if (bus_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Port drivers take their requests from queues.
// Bus transactions and responses are checked against expected queues that the tests fill.
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
  } dresp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq = 1'b0, iflush = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
  logic        iresp_valid, istall, dresp_valid, dstall;
  logic [31:0] irdata, drdata;
  logic        bus_valid, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  bus_t        exp_bus[$];
  logic [31:0] exp_i[$];
  dresp_t      exp_d[$];
  logic [31:0] i_todo[$];
  bus_t        d_todo[$];

  int first_i, first_d, n_iresp, n_dresp, n_istall, n_dstall, n_bv;

  // Memory model: ready after wait_n idle busy cycles; read data is a fixed function of the address.
  int wait_n = 0;
  int busy_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C08_0004;
    if (a == 32'h1001_0004) return 32'h1234_5678;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  assign bus_ready = bus_valid && (busy_cnt >= wait_n);
  assign bus_rdata = bus_valid ? mem_word(bus_addr) : 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset)                       busy_cnt <= 0;
    else if (bus_valid && !bus_ready) busy_cnt <= busy_cnt + 1;
    else                              busy_cnt <= 0;
  end

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iflush(iflush),
    .iresp_valid(iresp_valid), .irdata(irdata), .istall(istall),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dresp_valid(dresp_valid), .drdata(drdata), .dstall(dstall),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  // Scoreboard and protocol monitor, sampled on the falling edge.
  bus_t        mb;
  dresp_t      md;
  logic [31:0] mi;
  logic        hold = 1'b0;
  bus_t        held;

  always @(negedge clk) begin
    n_vec++;
    if (istall !== (ireq & ~iresp_valid)) begin
      n_err++; $display("FAIL istall: got %b expected %b", istall, ireq & ~iresp_valid);
    end
    n_vec++;
    if (dstall !== (dreq & ~dresp_valid)) begin
      n_err++; $display("FAIL dstall: got %b expected %b", dstall, dreq & ~dresp_valid);
    end
    if (hold && bus_valid) begin
      n_vec++;
      if (bus_we !== held.we || bus_addr !== held.addr || bus_wdata !== held.wdata) begin
        n_err++; $display("FAIL bus_stable: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                          bus_we, bus_addr, bus_wdata, held.we, held.addr, held.wdata);
      end
    end
    hold = bus_valid && !bus_ready;
    held = '{bus_we, bus_addr, bus_wdata};
    if (bus_valid && bus_ready) begin
      n_vec++;
      if (exp_bus.size() == 0) begin
        n_err++; $display("FAIL bus_txn: got unexpected we=%b addr=%h expected none", bus_we, bus_addr);
      end else begin
        mb = exp_bus.pop_front();
        if (bus_we !== mb.we || bus_addr !== mb.addr || (mb.we && bus_wdata !== mb.wdata)) begin
          n_err++; $display("FAIL bus_txn: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                            bus_we, bus_addr, bus_wdata, mb.we, mb.addr, mb.wdata);
        end
      end
    end
    if (iresp_valid) begin
      n_vec++;
      if (exp_i.size() == 0) begin
        n_err++; $display("FAIL iresp: got unexpected irdata=%h expected none", irdata);
      end else begin
        mi = exp_i.pop_front();
        if (irdata !== mi) begin
          n_err++; $display("FAIL irdata: got %h expected %h", irdata, mi);
        end
      end
    end
    if (dresp_valid) begin
      n_vec++;
      if (exp_d.size() == 0) begin
        n_err++; $display("FAIL dresp: got unexpected drdata=%h expected none", drdata);
      end else begin
        md = exp_d.pop_front();
        if (!md.we && drdata !== md.rdata) begin
          n_err++; $display("FAIL drdata: got %h expected %h", drdata, md.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_ports();
    ireq = (i_todo.size() != 0);
    if (ireq) iaddr = i_todo[0];
    dreq = (d_todo.size() != 0);
    if (dreq) begin
      dwe = d_todo[0].we; daddr = d_todo[0].addr; dwdata = d_todo[0].wdata;
    end
  endtask

  // Runs both requesters from their todo queues until drained, counting cycles from 1.
  task automatic run_ports(input int max_cyc);
    int  cyc = 0;
    logic ir, dr;
    first_i = 0; first_d = 0; n_iresp = 0; n_dresp = 0; n_istall = 0; n_dstall = 0; n_bv = 0;
    load_ports();
    while ((i_todo.size() != 0 || d_todo.size() != 0) && cyc < max_cyc) begin
      cyc++;
      @(negedge clk);
      ir = iresp_valid; dr = dresp_valid;
      if (ir) begin n_iresp++; if (first_i == 0) first_i = cyc; end
      if (dr) begin n_dresp++; if (first_d == 0) first_d = cyc; end
      if (istall)    n_istall++;
      if (dstall)    n_dstall++;
      if (bus_valid) n_bv++;
      tick();
      if (ir) void'(i_todo.pop_front());
      if (dr) void'(d_todo.pop_front());
      load_ports();
    end
    n_vec++;
    if (i_todo.size() != 0 || d_todo.size() != 0) begin
      n_err++; $display("FAIL run_timeout: got %0d/%0d requests left after %0d cycles expected 0/0",
                        i_todo.size(), d_todo.size(), max_cyc);
      i_todo.delete(); d_todo.delete();
    end
    ireq = 1'b0; dreq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if ({bus_valid, bus_we, bus_addr, bus_wdata, iresp_valid, dresp_valid} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got valid=%b we=%b addr=%h wdata=%h ir=%b dr=%b expected all 0",
                        bus_valid, bus_we, bus_addr, bus_wdata, iresp_valid, dresp_valid);
    end
    ireq = 1'b1; dreq = 1'b1; iaddr = 32'h0040_0000;
    repeat (2) tick();
    n_vec++;
    if (istall !== 1'b1 || dstall !== 1'b1 || bus_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got istall=%b dstall=%b bus_valid=%b expected 1 1 0",
                        istall, dstall, bus_valid);
    end
    ireq = 1'b0; dreq = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_lone_fetch();
    wait_n = 0;
    i_todo.push_back(32'h0040_0000);
    exp_bus.push_back('{1'b0, 32'h0040_0000, 32'h0});
    exp_i.push_back(32'h8C08_0004);
    run_ports(20);
    n_vec++;
    if (first_i != 2 || n_istall != 1 || n_iresp != 1) begin
      n_err++; $display("FAIL lone_fetch: got iresp cycle %0d stall cycles %0d resps %0d expected 2 1 1",
                        first_i, n_istall, n_iresp);
    end
  endtask

  task automatic test_simultaneous();
    wait_n = 0;
    i_todo.push_back(32'h0040_0004);
    d_todo.push_back('{1'b1, 32'h1001_0000, 32'hDEAD_BEEF});
    exp_bus.push_back('{1'b1, 32'h1001_0000, 32'hDEAD_BEEF});
    exp_bus.push_back('{1'b0, 32'h0040_0004, 32'h0});
    exp_d.push_back('{1'b1, 32'h0});
    exp_i.push_back(mem_word(32'h0040_0004));
    run_ports(20);
    n_vec++;
    if (first_d != 2 || first_i != 4) begin
      n_err++; $display("FAIL simultaneous: got dresp cycle %0d iresp cycle %0d expected 2 4", first_d, first_i);
    end
  endtask

  task automatic test_starvation();
    wait_n = 0;
    for (int k = 0; k < 5; k++)
      d_todo.push_back('{1'b0, 32'h1001_0100 + 32'(4 * k), 32'h0});
    i_todo.push_back(32'h0040_0008);
    i_todo.push_back(32'h0040_000C);
    for (int k = 0; k < 4; k++) begin
      exp_bus.push_back('{1'b0, 32'h1001_0100 + 32'(4 * k), 32'h0});
      exp_d.push_back('{1'b0, mem_word(32'h1001_0100 + 32'(4 * k))});
    end
    exp_bus.push_back('{1'b0, 32'h0040_0008, 32'h0});
    exp_i.push_back(mem_word(32'h0040_0008));
    exp_bus.push_back('{1'b0, 32'h1001_0110, 32'h0});
    exp_d.push_back('{1'b0, mem_word(32'h1001_0110)});
    exp_bus.push_back('{1'b0, 32'h0040_000C, 32'h0});
    exp_i.push_back(mem_word(32'h0040_000C));
    run_ports(40);
    n_vec++;
    if (first_i != 10 || n_dresp != 5 || n_iresp != 2) begin
      n_err++; $display("FAIL starvation: got first iresp cycle %0d dresps %0d iresps %0d expected 10 5 2",
                        first_i, n_dresp, n_iresp);
    end
  endtask

  task automatic test_flush_mid_fetch();
    wait_n = 3;
    exp_bus.push_back('{1'b0, 32'h0040_0010, 32'h0});
    exp_bus.push_back('{1'b0, 32'h0040_0020, 32'h0});
    exp_i.push_back(mem_word(32'h0040_0020));
    ireq = 1'b1; iaddr = 32'h0040_0010;
    tick();
    iflush = 1'b1; iaddr = 32'h0040_0020;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus_valid !== 1'b1 || iresp_valid !== 1'b0 || bus_addr !== 32'h0040_0010) begin
        n_err++; $display("FAIL flush_busy%0d: got bus_valid=%b iresp=%b addr=%h expected 1 0 00400010",
                          k, bus_valid, iresp_valid, bus_addr);
      end
      tick();
      iflush = 1'b0;
    end
    wait_n = 0;
    i_todo.push_back(32'h0040_0020);
    run_ports(20);
    n_vec++;
    if (first_i != 2) begin
      n_err++; $display("FAIL flush_refetch: got iresp cycle %0d expected 2", first_i);
    end
  endtask

  task automatic test_flush_edges();
    wait_n = 1;
    ireq = 1'b1; iaddr = 32'h0040_0040; iflush = 1'b1;
    tick();
    iflush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_idle: got bus_valid=%b expected 0", bus_valid);
    end
    exp_bus.push_back('{1'b0, 32'h0040_0040, 32'h0});
    tick();
    tick();
    iflush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus_ready !== 1'b1 || iresp_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_ready: got bus_ready=%b iresp=%b expected 1 0", bus_ready, iresp_valid);
    end
    tick();
    iflush = 1'b0; ireq = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_done: got bus_valid=%b expected 0", bus_valid);
    end
    tick();
  endtask

  task automatic test_wait_states();
    wait_n = 4;
    d_todo.push_back('{1'b0, 32'h1001_0004, 32'h0});
    exp_bus.push_back('{1'b0, 32'h1001_0004, 32'h0});
    exp_d.push_back('{1'b0, 32'h1234_5678});
    run_ports(20);
    n_vec++;
    if (n_dstall != 5 || n_bv != 5 || n_dresp != 1) begin
      n_err++; $display("FAIL wait_states: got dstall %0d bus_valid %0d dresp %0d expected 5 5 1",
                        n_dstall, n_bv, n_dresp);
    end
  endtask

  task automatic test_reset_mid();
    wait_n = 100;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h1001_0008;
    tick();
    @(negedge clk);
    n_vec++;
    if (bus_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_busy: got bus_valid=%b expected 1", bus_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (bus_valid !== 1'b0 || dresp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_abort: got bus_valid=%b dresp=%b expected 0 0", bus_valid, dresp_valid);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_idle: got bus_valid=%b expected 0", bus_valid);
    end
    tick();
    wait_n = 0;
    d_todo.push_back('{1'b0, 32'h1001_0008, 32'h0});
    exp_bus.push_back('{1'b0, 32'h1001_0008, 32'h0});
    exp_d.push_back('{1'b0, mem_word(32'h1001_0008)});
    run_ports(10);
    n_vec++;
    if (first_d != 1 || n_bv != 1) begin
      n_err++; $display("FAIL reset_mid_regrant: got dresp cycle %0d bus_valid cycles %0d expected 1 1",
                        first_d, n_bv);
    end
  endtask

  task automatic test_back_to_back();
    wait_n = 1;
    for (int k = 0; k < 4; k++) begin
      bus_t t;
      t = '{k[0], 32'h1002_0000 + 32'(8 * k), 32'hC0DE_0000 + 32'(k)};
      d_todo.push_back(t);
      exp_bus.push_back(t);
      exp_d.push_back('{t.we, mem_word(t.addr)});
    end
    run_ports(40);
    n_vec++;
    if (n_dresp != 4 || first_d != 3) begin
      n_err++; $display("FAIL back_to_back: got dresps %0d first at %0d expected 4 3", n_dresp, first_d);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_flush_mid_fetch();
    test_flush_edges();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    repeat (2) tick();
    n_vec++;
    if (exp_bus.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0) begin
      n_err++; $display("FAIL leftover: got bus %0d i %0d d %0d pending expected 0 0 0",
                        exp_bus.size(), exp_i.size(), exp_d.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
